inst_buffer: RTL and testbench
==============================

INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning entry count (power of two, at least 2*BLOCK_INST_SIZE).
REQ-002 SHALL have parameter BLOCK_INST_SIZE, default `BLOCK_INST_SIZE, meaning the maximum instructions written per cycle.
REQ-003 SHALL have parameter FETCH_WIDTH, default `FETCH_WIDTH, meaning the maximum instructions read per cycle.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_en, input, BLOCK_INST_SIZE bits: per-lane valid from predecode, compacted so that lanes 0..in_num-1 are valid.
REQ-007 SHALL have port in_num, input, $clog2(BLOCK_INST_SIZE)+1 bits: count of valid input lanes.
REQ-008 SHALL have port in_inst, input, BLOCK_INST_SIZE x 32 bits: the instruction words.
REQ-009 SHALL have port in_fsqIdx, input, FSQ_WIDTH bits: the fetch-stream index shared by all lanes of the write.
REQ-010 SHALL have port flush, input, 1 bit: frontend or backend redirect.
REQ-011 SHALL have port stall, input, 1 bit: decode back-pressure.
REQ-012 SHALL have port full, output, 1 bit: asserted when free entries < BLOCK_INST_SIZE.
REQ-013 SHALL have port out_en, output, FETCH_WIDTH bits: per-lane valid to decode, compacted.
REQ-014 SHALL have port out_inst, output, FETCH_WIDTH x 32 bits, and port out_fsqIdx, output, FETCH_WIDTH x FSQ_WIDTH bits: the instruction word and owning stream index of each output lane.

Function
REQ-015 SHALL be a circular queue holding {inst, fsqIdx} per entry, with head and tail pointers each carrying a wrap bit, plus a count register of $clog2(DEPTH)+1 bits.
REQ-016 SHALL write in_num entries at tail, in lane order, when in_num>0, full=0 and flush=0; otherwise the write is dropped and upstream holds.
REQ-017 SHALL present lanes i < min(count, FETCH_WIDTH) from head+i combinationally on out_en/out_inst/out_fsqIdx.
REQ-018 SHALL, when stall=0, advance head by the number of set out_en bits at the clock edge; when stall=1, keep head and the outputs unchanged.
REQ-019 SHALL, on a cycle with both a write and a read, update count as count + in_num - read_num in a single cycle.
REQ-020 SHALL compute full from the registered count only, never from the current cycle's read.
REQ-021 SHALL, when flush=1, reset head, tail and count to 0 at the next edge, drop the same-cycle write, and force out_en=0 in the flush cycle.
REQ-022 SHALL handle pointer wrap using modulo-DEPTH arithmetic, with the wrap bit toggling each time a pointer passes DEPTH-1.
REQ-023 SHALL give an instruction a write-to-output latency of 1 cycle when bypass is disabled.

Reset
REQ-024 SHALL, while rst=0, clear head, tail and count to 0 and drive full=0 and out_en=0; entry payload SHALL NOT be reset.
REQ-025 SHALL, on reset asserted mid-operation, discard all contents immediately, regardless of stall or flush.

Configuration
REQ-026 SHALL provide macro IBUF_BYPASS_EN; when it is defined and count=0, stall=0 and flush=0, the first min(in_num, FETCH_WIDTH) input lanes SHALL drive the outputs in the same cycle and only the remaining lanes SHALL be written.
REQ-027 SHALL, when IBUF_BYPASS_EN is undefined, omit the bypass path entirely and give a fixed 1-cycle latency.

Structure
REQ-028 SHALL take FETCH_WIDTH, BLOCK_INST_SIZE and FSQ_WIDTH from the shared defines, and SHALL define a shared typedef IBufEntry {inst, fsqIdx} alongside the other bundles.
REQ-029 SHALL instantiate one sub-module, ibuf_compact, a combinational mux that selects the FETCH_WIDTH head entries with wrap; all other logic SHALL be inline.

Verification
REQ-030 SHALL check empty-buffer write: in_num=4 (inst 0x13,0x93,0x113,0x193), stall=0, bypass off -> next cycle out_en=4'b1111 (FETCH_WIDTH=4) with those words in order, then count=0.
REQ-031 SHALL check fill-to-full: DEPTH=32, BLOCK_INST_SIZE=8, stall=1, in_num=8 for 4 cycles -> full=0 at count 24, full=1 after count=25+, and a further write is dropped with count unchanged.
REQ-032 SHALL check wrap: fill to 30, drain 28, write 8 -> tail wraps to 6 and outputs keep program order across index 31->0.
REQ-033 SHALL check simultaneous read/write: count=4, in_num=8, stall=0, FETCH_WIDTH=4 -> next count=8.
REQ-034 SHALL check flush with write: flush=1 with in_num=8 -> out_en=0 that cycle, count=0 next cycle, no stale instructions output afterward.
REQ-035 SHALL check bypass (IBUF_BYPASS_EN defined): count=0, in_num=6 -> 4 lanes output in the same cycle, 2 buffered, count=2 next cycle.

Source files
------------

// File: rtl/inst_buffer_pkg.sv
// Shared frontend bundles for the instruction buffer.
// Shared defines BLOCK_INST_SIZE, FETCH_WIDTH and FSQ_WIDTH fall back to defaults here if unset.
`ifndef BLOCK_INST_SIZE
`define BLOCK_INST_SIZE 8
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef FSQ_WIDTH
`define FSQ_WIDTH 4
`endif

package inst_buffer_pkg;

  localparam int unsigned FSQ_WIDTH = `FSQ_WIDTH;

  typedef struct packed {
    logic [31:0]          inst;
    logic [FSQ_WIDTH-1:0] fsqIdx;
  } IBufEntry;

endpackage

// File: rtl/ibuf_compact.sv
// Selects the FETCH_WIDTH oldest entries starting at head, wrapping modulo DEPTH.
module ibuf_compact
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned FETCH_WIDTH = 4
) (
  input  IBufEntry                   mem [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  output logic [FETCH_WIDTH-1:0]     out_en,
  output IBufEntry                   out_entry [FETCH_WIDTH]
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      out_en[i]    = CW'(i) < count;
      out_entry[i] = mem[head + AW'(i)];
    end
  end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction buffer between predecode and decode.
// Optional same-cycle bypass when empty is enabled by defining IBUF_BYPASS_EN.
`ifndef BLOCK_INST_SIZE
`define BLOCK_INST_SIZE 8
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH           = 32,
  parameter int unsigned BLOCK_INST_SIZE = `BLOCK_INST_SIZE,
  parameter int unsigned FETCH_WIDTH     = `FETCH_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [BLOCK_INST_SIZE-1:0]             in_en,
  input  logic [$clog2(BLOCK_INST_SIZE):0]       in_num,
  input  logic [BLOCK_INST_SIZE-1:0][31:0]       in_inst,
  input  logic [FSQ_WIDTH-1:0]                   in_fsqIdx,
  input  logic                                   flush,
  input  logic                                   stall,
  output logic                                   full,
  output logic [FETCH_WIDTH-1:0]                 out_en,
  output logic [FETCH_WIDTH-1:0][31:0]           out_inst,
  output logic [FETCH_WIDTH-1:0][FSQ_WIDTH-1:0]  out_fsqIdx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NW = $clog2(BLOCK_INST_SIZE) + 1;

  // head/tail carry a wrap bit above the index bits
  logic [CW-1:0]              head_q, tail_q, count_q;
  IBufEntry                   mem_q [DEPTH];
  IBufEntry                   buf_entry [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0]     buf_en;
  logic                       wr_en;
  logic [NW-1:0]              byp_num, wr_num;
  logic [CW-1:0]              rd_num;
  logic [AW-1:0]              wr_idx [BLOCK_INST_SIZE];
  logic [BLOCK_INST_SIZE-1:0] wr_lane;

  assign full = count_q > CW'(DEPTH - BLOCK_INST_SIZE);

`ifdef IBUF_BYPASS_EN
  logic byp_act;
  assign byp_act = (count_q == '0) && !stall && !flush && (in_num != '0);
  assign byp_num = !byp_act ? '0 :
                   (in_num > NW'(FETCH_WIDTH)) ? NW'(FETCH_WIDTH) : in_num;
`else
  assign byp_num = '0;
`endif

  assign wr_en  = (in_num != '0) && !full && !flush;
  assign wr_num = wr_en ? in_num - byp_num : '0;
  assign rd_num = (stall || flush) ? '0 :
                  (count_q > CW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH) : count_q;

  // Bypassed lanes are skipped; the rest pack from tail in lane order.
  always_comb begin
    for (int j = 0; j < BLOCK_INST_SIZE; j++) begin
      wr_lane[j] = wr_en && in_en[j] && (NW'(j) >= byp_num) && (NW'(j) < in_num);
      wr_idx[j]  = tail_q[AW-1:0] + AW'(j) - AW'(byp_num);
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < BLOCK_INST_SIZE; j++) begin
      if (wr_lane[j]) mem_q[wr_idx[j]] <= '{inst: in_inst[j], fsqIdx: in_fsqIdx};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + rd_num;
      tail_q  <= tail_q + CW'(wr_num);
      count_q <= count_q + CW'(wr_num) - rd_num;
    end
  end

  ibuf_compact #(
    .DEPTH       (DEPTH),
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_compact (
    .mem       (mem_q),
    .head      (head_q[AW-1:0]),
    .count     (count_q),
    .out_en    (buf_en),
    .out_entry (buf_entry)
  );

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      out_en[i]     = buf_en[i];
      out_inst[i]   = buf_entry[i].inst;
      out_fsqIdx[i] = buf_entry[i].fsqIdx;
`ifdef IBUF_BYPASS_EN
      if (byp_act) begin
        out_en[i]     = in_en[i] && (NW'(i) < byp_num);
        out_inst[i]   = in_inst[i];
        out_fsqIdx[i] = in_fsqIdx;
      end
`endif
      if (flush || !rst) out_en[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (DEPTH=32, BLOCK_INST_SIZE=8, FETCH_WIDTH=4).
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 32;
  localparam int BIS   = 8;
  localparam int FW    = 4;

  logic                               clk = 1'b0;
  logic                               rst = 1'b0;
  logic [BIS-1:0]                     in_en;
  logic [3:0]                         in_num;
  logic [BIS-1:0][31:0]               in_inst;
  logic [FSQ_WIDTH-1:0]               in_fsqIdx;
  logic                               flush;
  logic                               stall;
  logic                               full;
  logic [FW-1:0]                      out_en;
  logic [FW-1:0][31:0]                out_inst;
  logic [FW-1:0][FSQ_WIDTH-1:0]       out_fsqIdx;

  int checks = 0;
  int errors = 0;
  IBufEntry exp_q[$];

  always #5 clk = ~clk;

  inst_buffer #(
    .DEPTH           (DEPTH),
    .BLOCK_INST_SIZE (BIS),
    .FETCH_WIDTH     (FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .in_num     (in_num),
    .in_inst    (in_inst),
    .in_fsqIdx  (in_fsqIdx),
    .flush      (flush),
    .stall      (stall),
    .full       (full),
    .out_en     (out_en),
    .out_inst   (out_inst),
    .out_fsqIdx (out_fsqIdx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input int n, input logic [31:0] base, input int step, input int fsq);
    in_num    = 4'(n);
    in_fsqIdx = FSQ_WIDTH'(fsq);
    for (int j = 0; j < BIS; j++) begin
      in_en[j]   = (j < n);
      in_inst[j] = base + 32'(j * step);
    end
  endtask

  task automatic push_model(input int first, input int n, input logic [31:0] base,
                            input int step, input int fsq);
    for (int j = first; j < n; j++) exp_q.push_back('{inst: base + 32'(j * step),
                                                       fsqIdx: FSQ_WIDTH'(fsq)});
  endtask

  // Reads with stall=0 until the model is empty or the cycle budget runs out.
  task automatic drain(input int max_cycles, output int got);
    int lanes;
    logic [FW-1:0] exp_en;
    got   = 0;
    stall = 1'b0;
    flush = 1'b0;
    set_write(0, 32'h0, 0, 0);
    for (int c = 0; c < max_cycles; c++) begin
      #1;
      lanes  = (exp_q.size() < FW) ? exp_q.size() : FW;
      exp_en = FW'((1 << lanes) - 1);
      checks++;
      if (out_en !== exp_en) begin
        errors++;
        $display("FAIL drain_en: out_en=%b expected %b", out_en, exp_en);
      end
      for (int i = 0; i < lanes; i++) begin
        checks++;
        if (out_inst[i] !== exp_q[i].inst || out_fsqIdx[i] !== exp_q[i].fsqIdx) begin
          errors++;
          $display("FAIL drain_data lane %0d: got %h/%h expected %h/%h", i, out_inst[i],
                   out_fsqIdx[i], exp_q[i].inst, exp_q[i].fsqIdx);
        end
      end
      got += $countones(out_en);
      for (int i = 0; i < lanes; i++) void'(exp_q.pop_front());
      if (lanes == 0) break;
      tick();
    end
  endtask

  task automatic test_reset();
    flush = 1'b0;
    stall = 1'b0;
    set_write(8, 32'h1000, 4, 2);
    tick();
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++;
    if (out_en !== 4'b0000) begin
      errors++; $display("FAIL reset_out_en: got %b expected 0000", out_en);
    end
    tick();
    rst = 1'b1;
    set_write(0, 32'h0, 0, 0);
    #1;
    checks++;
    if (out_en !== 4'b0000) begin
      errors++; $display("FAIL reset_empty: got %b expected 0000", out_en);
    end
  endtask

  task automatic test_empty_write();
    logic [31:0] want [4];
    want  = '{32'h13, 32'h93, 32'h113, 32'h193};
    stall = 1'b0;
    set_write(4, 32'h13, 32'h80, 1);
    #1;
    checks++;
    if (out_en !== 4'b0000) begin
      errors++; $display("FAIL latency_same_cycle: out_en=%b expected 0000", out_en);
    end
    tick();
    set_write(0, 32'h0, 0, 0);
    #1;
    checks++;
    if (out_en !== 4'b1111) begin
      errors++; $display("FAIL latency_next_cycle: out_en=%b expected 1111", out_en);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_inst[i] !== want[i] || out_fsqIdx[i] !== FSQ_WIDTH'(1)) begin
        errors++;
        $display("FAIL empty_write lane %0d: got %h/%h expected %h/1", i, out_inst[i],
                 out_fsqIdx[i], want[i]);
      end
    end
    tick();
    checks++;
    if (out_en !== 4'b0000) begin
      errors++; $display("FAIL empty_after_read: out_en=%b expected 0000", out_en);
    end
  endtask

`ifdef IBUF_BYPASS_EN
  task automatic test_bypass();
    int got;
    stall = 1'b0;
    set_write(6, 32'hC000, 4, 5);
    #1;
    checks++;
    if (out_en !== 4'b1111 || out_inst[0] !== 32'hC000 || out_inst[3] !== 32'hC00C ||
        out_fsqIdx[3] !== FSQ_WIDTH'(5)) begin
      errors++;
      $display("FAIL bypass_same_cycle: en=%b inst0=%h inst3=%h expected 1111/c000/c00c",
               out_en, out_inst[0], out_inst[3]);
    end
    push_model(4, 6, 32'hC000, 4, 5);
    tick();
    set_write(0, 32'h0, 0, 0);
    stall = 1'b1;
    #1;
    checks++;
    if (out_en !== 4'b0011 || out_inst[0] !== 32'hC010) begin
      errors++;
      $display("FAIL bypass_buffered: en=%b inst0=%h expected 0011/c010", out_en, out_inst[0]);
    end
    drain(4, got);
    checks++;
    if (got !== 2) begin errors++; $display("FAIL bypass_count: got %0d expected 2", got); end
  endtask
`endif

  task automatic test_fill_full();
    int got;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_write(8, 32'h1000 + 32'(k * 32'h100), 4, k);
      push_model(0, 8, 32'h1000 + 32'(k * 32'h100), 4, k);
      tick();
    end
    set_write(1, 32'h2000, 4, 3);
    push_model(0, 1, 32'h2000, 4, 3);
    #1;
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL full_at_24: got %b expected 0", full); end
    tick();
    set_write(8, 32'h3000, 4, 4);
    #1;
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full_at_25: got %b expected 1", full); end
    checks++;
    if (out_en !== 4'b1111 || out_inst[0] !== 32'h1000) begin
      errors++;
      $display("FAIL stall_hold: en=%b inst0=%h expected 1111/1000", out_en, out_inst[0]);
    end
    tick();
    drain(20, got);
    checks++;
    if (got !== 25) begin errors++; $display("FAIL full_drop: drained %0d expected 25", got); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL full_cleared: got %b expected 0", full); end
  endtask

  task automatic test_wrap();
    int got;
    flush = 1'b1;
    set_write(0, 32'h0, 0, 0);
    tick();
    flush = 1'b0;
    exp_q.delete();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_write((k == 3) ? 6 : 8, 32'h4000 + 32'(k * 32'h100), 4, k);
      push_model(0, (k == 3) ? 6 : 8, 32'h4000 + 32'(k * 32'h100), 4, k);
      tick();
    end
    drain(7, got);
    checks++;
    if (got !== 28) begin errors++; $display("FAIL wrap_drain28: got %0d expected 28", got); end
    stall = 1'b1;
    set_write(8, 32'h5000, 4, 9);
    push_model(0, 8, 32'h5000, 4, 9);
    tick();
    set_write(0, 32'h0, 0, 0);
    #1;
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL wrap_full: got %b expected 0", full); end
    drain(10, got);
    checks++;
    if (got !== 10) begin errors++; $display("FAIL wrap_count: got %0d expected 10", got); end
  endtask

  task automatic test_simultaneous();
    int got;
    stall = 1'b1;
    set_write(4, 32'h6000, 4, 6);
    push_model(0, 4, 32'h6000, 4, 6);
    tick();
    stall = 1'b0;
    set_write(8, 32'h7000, 4, 7);
    #1;
    checks++;
    if (out_en !== 4'b1111 || out_inst[0] !== 32'h6000) begin
      errors++;
      $display("FAIL simul_read: en=%b inst0=%h expected 1111/6000", out_en, out_inst[0]);
    end
    for (int i = 0; i < 4; i++) void'(exp_q.pop_front());
    push_model(0, 8, 32'h7000, 4, 7);
    tick();
    set_write(0, 32'h0, 0, 0);
    stall = 1'b1;
    #1;
    checks++;
    if (out_en !== 4'b1111 || out_inst[0] !== 32'h7000) begin
      errors++;
      $display("FAIL simul_after: en=%b inst0=%h expected 1111/7000", out_en, out_inst[0]);
    end
    drain(10, got);
    checks++;
    if (got !== 8) begin errors++; $display("FAIL simul_count: got %0d expected 8", got); end
  endtask

  task automatic test_flush();
    int got;
    stall = 1'b1;
    set_write(6, 32'h8000, 4, 8);
    tick();
    flush = 1'b1;
    stall = 1'b0;
    set_write(8, 32'h9000, 4, 8);
    #1;
    checks++;
    if (out_en !== 4'b0000) begin
      errors++; $display("FAIL flush_out_en: got %b expected 0000", out_en);
    end
    tick();
    flush = 1'b0;
    set_write(0, 32'h0, 0, 0);
    #1;
    checks++;
    if (out_en !== 4'b0000 || full !== 1'b0) begin
      errors++; $display("FAIL flush_empty: en=%b full=%b expected 0000/0", out_en, full);
    end
    stall = 1'b1;
    set_write(2, 32'hA000, 4, 10);
    push_model(0, 2, 32'hA000, 4, 10);
    tick();
    drain(5, got);
    checks++;
    if (got !== 2) begin errors++; $display("FAIL flush_stale: got %0d expected 2", got); end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    set_write(5, 32'hB000, 4, 11);
    tick();
    set_write(0, 32'h0, 0, 0);
    #1;
    checks++;
    if (out_en !== 4'b1111) begin
      errors++; $display("FAIL mid_pre: out_en=%b expected 1111", out_en);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (out_en !== 4'b0000 || full !== 1'b0) begin
      errors++; $display("FAIL mid_reset: en=%b full=%b expected 0000/0", out_en, full);
    end
    tick();
    rst   = 1'b1;
    stall = 1'b0;
    #1;
    checks++;
    if (out_en !== 4'b0000) begin
      errors++; $display("FAIL mid_discard: out_en=%b expected 0000", out_en);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef IBUF_BYPASS_EN
    test_bypass();
`else
    test_empty_write();
`endif
    test_fill_full();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
